// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
// States, op encoding and address-map defaults.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int          SRAM_AW_DEF   = 18;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// MEM-stage request bus: load/store request in, result and ready out.
// master = MEM stage, slave = memory controller.
interface sram_mem_ctrl_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_phase_counter.sv
// Cycle counter for one 16-bit half-access (0..WAIT-1).
// stb reflects the count the SRAM pins will carry next cycle.
module sram_phase_counter #(
  parameter int WAIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last,
  output logic stb
);

  logic [3:0] count;
  logic [3:0] count_d;

  always_comb begin
    count_d = count;
    if (clr)
      count_d = '0;
    else if (en)
      count_d = count + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else
      count <= count_d;
  end

  assign last = (count == 4'(WAIT - 1));
  assign stb  = (count_d < 4'(WAIT - 1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// Serves 32-bit MEM-stage loads/stores from a 16-bit async SRAM,
// low halfword then high halfword, WAIT cycles each.
module sram_mem_ctrl
  import arm_mem_pkg::*;
#(
  parameter int          WAIT      = 3,
  parameter int          SRAM_AW   = SRAM_AW_DEF,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_ctrl_if.slave     bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  state_t               state, state_d;
  op_t                  op_q, op_d;
  logic [SRAM_AW-1:0]   hw_q, hw_d, hw_in;
  logic [31:0]          wd_q, wd_d, off;
  logic [31:0]          rdata;
  logic                 req, last, stb, clr, en;
  logic                 cap_lo, cap_hi, act, wr;
  logic [SRAM_AW-1:0]   addr_d;
  logic [15:0]          dqo_d;

  assign req   = bus.rd_en | bus.wr_en;
  assign off   = bus.address - BASE_ADDR;
  assign hw_in = SRAM_AW'((off >> 2) << 1);

  sram_phase_counter #(.WAIT(WAIT)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .last (last),
    .stb  (stb)
  );

  always_comb begin
    state_d = state;
    op_d    = op_q;
    hw_d    = hw_q;
    wd_d    = wd_q;
    clr     = 1'b1;
    en      = 1'b0;
    cap_lo  = 1'b0;
    cap_hi  = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        state_d = LOW;
        op_d    = bus.wr_en ? OP_WR : OP_RD;
        hw_d    = hw_in;
        wd_d    = bus.write_data;
      end
      LOW: begin
        clr    = last;
        en     = ~last;
        cap_lo = last && (op_q == OP_RD);
        if (last) state_d = HIGH;
      end
      HIGH: begin
        clr    = last;
        en     = ~last;
        cap_hi = last && (op_q == OP_RD);
        if (last) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered, so they are decoded from next-cycle state.
  always_comb begin
    act    = (state_d == LOW) || (state_d == HIGH);
    wr     = (op_d == OP_WR);
    addr_d = '0;
    dqo_d  = '0;
    if (act) begin
      addr_d = (state_d == HIGH) ? {hw_d[SRAM_AW-1:1], 1'b1} : hw_d;
      if (wr)
        dqo_d = (state_d == HIGH) ? wd_d[31:16] : wd_d[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_RD;
      hw_q        <= '0;
      wd_q        <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_ce_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      hw_q        <= hw_d;
      wd_q        <= wd_d;
      if (cap_lo) rdata[15:0]  <= sram_dq_in;
      if (cap_hi) rdata[31:16] <= sram_dq_in;
      sram_addr   <= addr_d;
      sram_dq_out <= dqo_d;
      sram_dq_oe  <= act && wr;
      sram_we_n   <= ~(act && wr && stb);
      sram_oe_n   <= ~(act && !wr);
      sram_ce_n   <= ~act;
      sram_ub_n   <= ~act;
      sram_lb_n   <= ~act;
    end
  end

  assign bus.read_data = rdata;
  assign bus.ready     = (state == IDLE) ? ~req : (state == DONE);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Randomized bench for sram_mem_ctrl against a word-level memory model.
// The SRAM is modelled as a halfword array behind the DUT pins.
module tb_sram_mem_ctrl;

  localparam int WAIT = 3;
  localparam int AW   = 18;
  localparam int LAT  = 2 * WAIT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sram_mem_ctrl_if bus ();

  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic          sram_ce_n;
  logic          sram_ub_n;
  logic          sram_lb_n;

  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] ref_mem [int];
  logic [31:0] last_rd;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_mem_ctrl #(
    .WAIT      (WAIT),
    .SRAM_AW   (AW),
    .BASE_ADDR (32'd1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .sram_ce_n   (sram_ce_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0;

  always @(negedge clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      mem[sram_addr] <= sram_dq_out;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word index from the CPU base, two halfwords per word, modulo SRAM size.
  function automatic logic [AW-1:0] hw_of(input logic [31:0] a);
    logic [31:0] word;
    word = (a - 32'd1024) / 4;
    return AW'(word * 2);
  endfunction

  task automatic chk_pins_idle(input string tag);
    chk({tag, "_ce"}, 32'(sram_ce_n), 32'd1);
    chk({tag, "_we"}, 32'(sram_we_n), 32'd1);
    chk({tag, "_oe"}, 32'(sram_oe_n), 32'd1);
    chk({tag, "_ub"}, 32'(sram_ub_n), 32'd1);
    chk({tag, "_lb"}, 32'(sram_lb_n), 32'd1);
    chk({tag, "_dqoe"}, 32'(sram_dq_oe), 32'd0);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_dqo"}, 32'(sram_dq_out), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.ready), 32'd1);
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit chg);
    int cyc;
    int wel;
    logic [AW-1:0] h;
    h = hw_of(a);
    @(posedge clk); #1;
    bus.rd_en = rd;
    bus.wr_en = wr;
    bus.address = a;
    bus.write_data = d;
    cyc = 0;
    wel = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (!sram_we_n) wel++;
      if (bus.ready) break;
      cyc++;
      if (chg && cyc == 1) begin
        @(posedge clk); #1;
        bus.address = 32'd2000;
        bus.write_data = 32'h0;
      end
    end
    chk("latency", 32'(cyc), 32'(LAT));
    if (wr) begin
      ref_mem[int'(h)]      = d[15:0];
      ref_mem[int'(h) + 1]  = d[31:16];
      chk("we_low", 32'(wel), 32'(2 * (WAIT - 1)));
      chk("mem", {mem[h + 1], mem[h]}, d);
    end else begin
      last_rd = {ref_mem[int'(h) + 1], ref_mem[int'(h)]};
    end
    chk("rdata", bus.read_data, last_rd);
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk("idle_rdy", 32'(bus.ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] rd7, rd15;
    logic ce [0:19];
    logic rdy [0:19];
    int ce_low;
    int k;

    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    last_rd = '0;
    #12;
    chk_pins_idle("rst");
    chk("rst_rdata", bus.read_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
    chk("hw4", 32'(mem[4]), 32'h0000BEEF);
    chk("hw5", 32'(mem[5]), 32'h0000DEAD);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    chk("rd_1032", bus.read_data, 32'hDEADBEEF);

    access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    chk("both_rdata", bus.read_data, 32'hDEADBEEF);
    chk("hw0", 32'(mem[0]), 32'h00005678);
    chk("hw1", 32'(mem[1]), 32'h00001234);

    access(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 1'b1);
    chk("latched_lo", 32'(mem[6]), 32'h0000F00D);
    chk("latched_hi", 32'(mem[7]), 32'h0000CAFE);

    access(1'b0, 1'b1, 32'd1028, 32'hAABBCCDD, 1'b0);

    // Request held through DONE; address switches in the IDLE cycle.
    @(posedge clk); #1;
    bus.rd_en = 1'b1;
    bus.address = 32'd1024;
    rd7 = '0;
    rd15 = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ce[c] = sram_ce_n;
      rdy[c] = bus.ready;
      if (c == 7) rd7 = bus.read_data;
      if (c == 15) rd15 = bus.read_data;
      @(posedge clk); #1;
      if (c == 7) bus.address = 32'd1028;
      if (c == 14) bus.rd_en = 1'b0;
    end
    ce_low = 0;
    for (int c = 0; c < 20; c++) if (!ce[c]) ce_low++;
    chk("b2b_ce_cycles", 32'(ce_low), 32'(4 * WAIT));
    chk("b2b_c8_idle", 32'(ce[8]), 32'd1);
    chk("b2b_c9_low", 32'(ce[9]), 32'd0);
    chk("b2b_rdy7", 32'(rdy[7]), 32'd1);
    chk("b2b_rdy15", 32'(rdy[15]), 32'd1);
    chk("b2b_rd1", rd7, 32'h12345678);
    chk("b2b_rd2", rd15, 32'hAABBCCDD);
    last_rd = rd15;

    access(1'b1, 1'b0, 32'd1027, 32'h0, 1'b0);
    chk("unaligned", bus.read_data, 32'h12345678);

    access(1'b0, 1'b1, 32'd0, 32'h0BADC0DE, 1'b0);
    chk("wrap_lo", 32'(mem[18'h3FE00]), 32'h0000C0DE);
    chk("wrap_hi", 32'(mem[18'h3FE01]), 32'h00000BAD);
    access(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
    chk("wrap_rd", bus.read_data, 32'h0BADC0DE);

    for (int w = 0; w < 16; w++)
      access(1'b0, 1'b1, 32'd1024 + 32'(4 * w), $urandom, 1'b0);
    for (int t = 0; t < 40; t++) begin
      a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d = $urandom;
      k = $urandom_range(0, 2);
      access(k != 1, k != 0, a, d, 1'b0);
    end

    // Async reset in the middle of the high-half write.
    @(posedge clk); #1;
    bus.wr_en = 1'b1;
    bus.address = 32'd1824;
    bus.write_data = 32'h55AA33CC;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    #1;
    chk_pins_idle("mid_rst");
    chk("mid_rst_rdata", bus.read_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
